// File: rtl/led_randomizer.sv
// led_randomizer: one-hot target generator for the hit_or_miss game.
// A 16-bit LFSR is reseeded from the hit_or_miss token, free-runs for SPIN_CYCLES and then
// supplies a one-hot LED target that is held until a hit or a timeout. Hit and miss totals
// are kept in saturating counters for the display stage.
// Optional feature macro: RAND_NO_REPEAT_EN (never show the same target twice in a row).
module led_randomizer #(
    parameter int unsigned SPIN_CYCLES    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000000,
    parameter logic [15:0] SEED           = 16'hACE1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       enable_i,
    input  logic       clear_i,
    input  logic [7:0] token_i,
    input  logic       hit_i,
    output logic [7:0] led_o,
    output logic       led_valid_o,
    output logic       round_done_o,
    output logic [7:0] hit_count_o,
    output logic [7:0] miss_count_o
);

    localparam int unsigned SpinW  = (SPIN_CYCLES > 1) ? $clog2(SPIN_CYCLES) : 1;
    localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES);
    localparam logic [SpinW-1:0]  SpinLast  = SpinW'(SPIN_CYCLES - 1);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StSeed, StSpin, StWait} state_e;

    state_e            state_q, state_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [7:0]        led_q, led_d;
    logic              led_valid_q, led_valid_d;
    logic              round_done_q, round_done_d;
    logic [7:0]        hit_cnt_q, hit_cnt_d;
    logic [7:0]        miss_cnt_q, miss_cnt_d;
    logic [2:0]        prev_idx_q, prev_idx_d;
    logic [SpinW-1:0]  spin_cnt_q, spin_cnt_d;
    logic [TimerW-1:0] timer_q, timer_d;

    logic [15:0] lfsr_step;
    logic [15:0] seed_mix;
    logic [2:0]  idx;

    assign lfsr_step = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign seed_mix  = lfsr_step ^ {8'h00, token_i};

`ifdef RAND_NO_REPEAT_EN
    // Set once the first target has been shown; gates the repeat-avoidance bump.
    logic shown_q, shown_d;

    // Bump a repeated index by one so a stale changed_bit cannot score an instant hit.
    always_comb begin
        idx = lfsr_q[2:0];
        if (shown_q && (lfsr_q[2:0] == prev_idx_q)) begin
            idx = lfsr_q[2:0] + 3'd1;
        end
    end
`else
    assign idx = lfsr_q[2:0];
`endif

    // Next-state and datapath decode for the round sequencer.
    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_step;
        led_d        = led_q;
        led_valid_d  = 1'b0;
        round_done_d = 1'b0;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        prev_idx_d   = prev_idx_q;
        spin_cnt_d   = spin_cnt_q;
        timer_d      = timer_q;
`ifdef RAND_NO_REPEAT_EN
        shown_d      = shown_q;
`endif

        unique case (state_q)
            StIdle: begin
                led_d = 8'h00;
                if (enable_i) begin
                    state_d = StSeed;
                end
            end
            StSeed: begin
                // A zero LFSR would lock up, so fall back to the reset seed.
                lfsr_d     = (seed_mix == 16'h0000) ? SEED : seed_mix;
                spin_cnt_d = '0;
                state_d    = StSpin;
            end
            StSpin: begin
                spin_cnt_d = spin_cnt_q + 1'b1;
                if (spin_cnt_q == SpinLast) begin
                    led_d       = 8'h01 << idx;
                    prev_idx_d  = idx;
                    timer_d     = '0;
                    led_valid_d = 1'b1;
                    state_d     = StWait;
`ifdef RAND_NO_REPEAT_EN
                    shown_d     = 1'b1;
`endif
                end
            end
            StWait: begin
                led_valid_d = 1'b1;
                timer_d     = timer_q + 1'b1;
                // Hit takes priority over a coincident timeout.
                if (hit_i) begin
                    hit_cnt_d    = (hit_cnt_q != 8'hFF) ? hit_cnt_q + 8'd1 : hit_cnt_q;
                    round_done_d = 1'b1;
                    led_d        = 8'h00;
                    led_valid_d  = 1'b0;
                    state_d      = StSeed;
                end else if (timer_q == TimerLast) begin
                    miss_cnt_d   = (miss_cnt_q != 8'hFF) ? miss_cnt_q + 8'd1 : miss_cnt_q;
                    round_done_d = 1'b1;
                    led_d        = 8'h00;
                    led_valid_d  = 1'b0;
                    state_d      = StSeed;
                end
            end
            default: begin
                state_d = StIdle;
                led_d   = 8'h00;
            end
        endcase

        // Disabling drops any in-flight round without counting it.
        if (!enable_i) begin
            state_d      = StIdle;
            led_d        = 8'h00;
            led_valid_d  = 1'b0;
            round_done_d = 1'b0;
            hit_cnt_d    = hit_cnt_q;
            miss_cnt_d   = miss_cnt_q;
            prev_idx_d   = prev_idx_q;
`ifdef RAND_NO_REPEAT_EN
            shown_d      = shown_q;
`endif
        end

        // Clear overrides any simultaneous count update.
        if (clear_i) begin
            hit_cnt_d  = 8'h00;
            miss_cnt_d = 8'h00;
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            lfsr_q       <= SEED;
            led_q        <= 8'h00;
            led_valid_q  <= 1'b0;
            round_done_q <= 1'b0;
            hit_cnt_q    <= 8'h00;
            miss_cnt_q   <= 8'h00;
            prev_idx_q   <= 3'd0;
            spin_cnt_q   <= '0;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            led_q        <= led_d;
            led_valid_q  <= led_valid_d;
            round_done_q <= round_done_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            prev_idx_q   <= prev_idx_d;
            spin_cnt_q   <= spin_cnt_d;
            timer_q      <= timer_d;
        end
    end

`ifdef RAND_NO_REPEAT_EN
    // Tracks whether any target has been shown since reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shown_q <= 1'b0;
        end else begin
            shown_q <= shown_d;
        end
    end
`endif

    assign led_o        = led_q;
    assign led_valid_o  = led_valid_q;
    assign round_done_o = round_done_q;
    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;

endmodule

// File: tb/tb_led_randomizer.sv
// Testbench for led_randomizer with SPIN_CYCLES=4 and TIMEOUT_CYCLES=16.
// Table rows carry per-edge inputs plus the expected post-edge phase and counter values;
// the LED target is predicted from a small LFSR model stepped along that phase timeline.
module tb_led_randomizer;

    localparam int unsigned Spin = 4;
    localparam int unsigned Tmo  = 16;
    localparam logic [15:0] SeedV = 16'hACE1;

    typedef enum logic [1:0] {MI, MS, MP, MW} mst_e;

    typedef struct {
        string      name;
        int         rep;
        logic       en;
        logic       clr;
        logic       hit;
        logic [7:0] tok;
        mst_e       st;
        logic       rd;
        logic [7:0] hc;
        logic [7:0] mc;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       enable;
    logic       clear;
    logic [7:0] token;
    logic       hit;
    logic [7:0] led;
    logic       led_valid;
    logic       round_done;
    logic [7:0] hit_count;
    logic [7:0] miss_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    mst_e        m_st;
    logic [15:0] m_lfsr;
    logic [7:0]  m_led;
    logic [2:0]  m_prev;
    logic        m_shown;

    vec_t tbl[$];

    led_randomizer #(
        .SPIN_CYCLES   (Spin),
        .TIMEOUT_CYCLES(Tmo),
        .SEED          (SeedV)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .enable_i    (enable),
        .clear_i     (clear),
        .token_i     (token),
        .hit_i       (hit),
        .led_o       (led),
        .led_valid_o (led_valid),
        .round_done_o(round_done),
        .hit_count_o (hit_count),
        .miss_count_o(miss_count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st    = MI;
        m_lfsr  = SeedV;
        m_led   = 8'h00;
        m_prev  = 3'd0;
        m_shown = 1'b0;
    endtask

    // Drive one edge, advance the model along the expected phase, compare all outputs.
    task automatic cycle(input string name, input logic en, input logic clr, input logic h,
                         input logic [7:0] tok, input mst_e ns, input logic rd,
                         input logic [7:0] hc, input logic [7:0] mc);
        logic [2:0] ix;
        enable = en;
        clear  = clr;
        hit    = h;
        token  = tok;
        @(posedge clk);
        #1;
        if (m_st == MS) begin
            m_lfsr = lfsr_next(m_lfsr) ^ {8'h00, tok};
            if (m_lfsr == 16'h0000) m_lfsr = SeedV;
        end else begin
            if (m_st == MP && ns == MW) begin
                ix = m_lfsr[2:0];
`ifdef RAND_NO_REPEAT_EN
                if (m_shown && ix == m_prev) ix = ix + 3'd1;
`endif
                m_led   = 8'h01 << ix;
                m_prev  = ix;
                m_shown = 1'b1;
            end
            m_lfsr = lfsr_next(m_lfsr);
        end
        if (ns != MW) m_led = 8'h00;
        m_st = ns;
        chk({name, ".led"}, {8'h00, led}, {8'h00, m_led});
        chk({name, ".led_valid"}, {15'h0, led_valid}, {15'h0, ns == MW});
        chk({name, ".round_done"}, {15'h0, round_done}, {15'h0, rd});
        chk({name, ".hit_count"}, {8'h00, hit_count}, {8'h00, hc});
        chk({name, ".miss_count"}, {8'h00, miss_count}, {8'h00, mc});
    endtask

    task automatic add(input string name, input int rep, input logic en, input logic clr,
                       input logic h, input logic [7:0] tok, input mst_e st, input logic rd,
                       input logic [7:0] hc, input logic [7:0] mc);
        vec_t v;
        v.name = name; v.rep = rep; v.en = en; v.clr = clr; v.hit = h; v.tok = tok;
        v.st = st; v.rd = rd; v.hc = hc; v.mc = mc;
        tbl.push_back(v);
    endtask

    // One hit round starting from SEED: four spin edges, target shown, then hit.
    task automatic hit_round(input string name, input logic [7:0] tok, inout int e_hc,
                             input int e_mc, output logic [7:0] tgt);
        for (int k = 0; k < 4; k++) cycle(name, 1, 0, 0, tok, MP, 0, 8'(e_hc), 8'(e_mc));
        cycle(name, 1, 0, 0, 8'h00, MW, 0, 8'(e_hc), 8'(e_mc));
        tgt = led;
        e_hc = (e_hc < 255) ? e_hc + 1 : 255;
        cycle(name, 1, 0, 1, 8'h00, MS, 1, 8'(e_hc), 8'(e_mc));
    endtask

    initial begin
        int         e_hc;
        logic [7:0] tgt;
        logic [7:0] prev_tgt;

        // name, rep, en, clr, hit, tok, next phase, round_done, hit_count, miss_count
        add("idle_hit",    3, 0, 0, 1, 8'h00, MI, 0, 0, 0);
        add("start_seed",  1, 1, 0, 0, 8'h00, MS, 0, 0, 0);
        add("start_spin",  4, 1, 0, 0, 8'h00, MP, 0, 0, 0);
        add("first_tgt",   1, 1, 0, 0, 8'h00, MW, 0, 0, 0);
        add("wait1",       2, 1, 0, 0, 8'h00, MW, 0, 0, 0);
        add("hit1",        1, 1, 0, 1, 8'h00, MS, 1, 1, 0);
        add("spin2",       4, 1, 0, 0, 8'h33, MP, 0, 1, 0);
        add("tgt2",        1, 1, 0, 0, 8'h00, MW, 0, 1, 0);
        add("wait2",      15, 1, 0, 0, 8'h00, MW, 0, 1, 0);
        add("timeout",     1, 1, 0, 0, 8'h00, MS, 1, 1, 1);
        add("spin3",       4, 1, 0, 0, 8'hC4, MP, 0, 1, 1);
        add("tgt3",        1, 1, 0, 0, 8'h00, MW, 0, 1, 1);
        add("wait3",      15, 1, 0, 0, 8'h00, MW, 0, 1, 1);
        add("hit_tmo",     1, 1, 0, 1, 8'h00, MS, 1, 2, 1);
        add("spin_hit",    4, 1, 0, 1, 8'h7E, MP, 0, 2, 1);
        add("tgt4",        1, 1, 0, 0, 8'h00, MW, 0, 2, 1);
        add("wait4",       1, 1, 0, 0, 8'h00, MW, 0, 2, 1);
        add("clr_hit",     1, 1, 1, 1, 8'h00, MS, 1, 0, 0);
        add("spin5",       4, 1, 0, 0, 8'h5A, MP, 0, 0, 0);
        add("tgt5",        1, 1, 0, 0, 8'h00, MW, 0, 0, 0);
        add("wait5",       1, 1, 0, 0, 8'h00, MW, 0, 0, 0);
        add("drop",        1, 0, 0, 1, 8'h00, MI, 0, 0, 0);
        add("idle2",       2, 0, 0, 1, 8'h00, MI, 0, 0, 0);

        rst_ni = 1'b0;
        enable = 1'b0;
        clear  = 1'b0;
        token  = 8'h00;
        hit    = 1'b0;
        model_reset();
        #10;
        chk("rst.led", {8'h00, led}, 16'h0000);
        chk("rst.led_valid", {15'h0, led_valid}, 16'h0000);
        chk("rst.round_done", {15'h0, round_done}, 16'h0000);
        chk("rst.hit_count", {8'h00, hit_count}, 16'h0000);
        chk("rst.miss_count", {8'h00, miss_count}, 16'h0000);
        #2 rst_ni = 1'b1;

        foreach (tbl[i]) begin
            for (int r = 0; r < tbl[i].rep; r++) begin
                cycle(tbl[i].name, tbl[i].en, tbl[i].clr, tbl[i].hit, tbl[i].tok,
                      tbl[i].st, tbl[i].rd, tbl[i].hc, tbl[i].mc);
            end
        end

        // 300 hits saturate hit_count at 255.
        e_hc = 0;
        cycle("sat_seed", 1, 0, 0, 8'h00, MS, 0, 8'h00, 8'h00);
        for (int r = 0; r < 300; r++) hit_round("sat", 8'(r * 37), e_hc, 0, tgt);
        chk("sat.final", {8'h00, hit_count}, 16'h00FF);

        // Disable mid-WAIT keeps counts, then a lone clear zeroes them.
        for (int k = 0; k < 4; k++) cycle("sat_spin", 1, 0, 0, 8'h11, MP, 0, 8'hFF, 8'h00);
        cycle("sat_tgt", 1, 0, 0, 8'h00, MW, 0, 8'hFF, 8'h00);
        cycle("sat_wait", 1, 0, 0, 8'h00, MW, 0, 8'hFF, 8'h00);
        cycle("sat_drop", 0, 0, 1, 8'h00, MI, 0, 8'hFF, 8'h00);
        cycle("clear_idle", 0, 1, 0, 8'h00, MI, 0, 8'h00, 8'h00);

        // 1000 rounds checked against the model; consecutive targets compared when enabled.
        e_hc = 0;
        prev_tgt = 8'h00;
        cycle("seq_seed", 1, 0, 0, 8'h00, MS, 0, 8'h00, 8'h00);
        for (int r = 0; r < 1000; r++) begin
            hit_round("seq", 8'(r * 13 + 5), e_hc, 0, tgt);
`ifdef RAND_NO_REPEAT_EN
            if (r > 0) chk("no_repeat", {15'h0, tgt != prev_tgt}, 16'h0001);
`endif
            prev_tgt = tgt;
        end

        // Asynchronous reset in the middle of WAIT.
        for (int k = 0; k < 4; k++) cycle("rr_spin", 1, 0, 0, 8'h22, MP, 0, 8'hFF, 8'h00);
        cycle("rr_tgt", 1, 0, 0, 8'h00, MW, 0, 8'hFF, 8'h00);
        #2 rst_ni = 1'b0;
        #1;
        chk("midrst.led", {8'h00, led}, 16'h0000);
        chk("midrst.led_valid", {15'h0, led_valid}, 16'h0000);
        chk("midrst.hit_count", {8'h00, hit_count}, 16'h0000);
        chk("midrst.miss_count", {8'h00, miss_count}, 16'h0000);
        model_reset();
        @(posedge clk);
        #2 rst_ni = 1'b1;
        cycle("post_rst_seed", 1, 0, 0, 8'h00, MS, 0, 8'h00, 8'h00);
        for (int k = 0; k < 4; k++) cycle("post_rst_spin", 1, 0, 0, 8'h00, MP, 0, 8'h00, 8'h00);
        cycle("post_rst_tgt", 1, 0, 0, 8'h00, MW, 0, 8'h00, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_randomizer.md
Name: led_randomizer

Overview:
- Upstream stage of hit_or_miss. Produces the one-hot target LED pattern that hit_or_miss compares against the flipped switch.
- Reseeds a 16-bit LFSR from the token that hit_or_miss returns, then holds the target until a hit or a timeout.
- Keeps saturating hit and miss counters for the display stage.

Parameters:
- SPIN_CYCLES, 4: LFSR free-run cycles between seeding and showing a new target; must be 1 or more.
- TIMEOUT_CYCLES, 50000000: maximum WAIT cycles per target (1 s at 50 MHz); must be 2 or more.
- SEED, 16'hACE1: LFSR reset value, and its replacement whenever the LFSR would become zero; must be nonzero.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- enable  in  1  level; 1 = game running, 0 = return to IDLE.
- clear  in  1  single-cycle pulse; zeroes hit_count and miss_count.
- token  in  8  token from hit_or_miss; used as seed entropy.
- hit  in  1  hit flag from hit_or_miss (combinational on LED).
- LED  out  8  one-hot target; 8'h00 when no target is shown.
- led_valid  out  1  high while in WAIT.
- round_done  out  1  one-cycle pulse on the edge that ends a round.
- hit_count  out  8  saturating count of hits.
- miss_count  out  8  saturating count of timeouts.

Behaviour:
- Reset (rst=0, asynchronous), all registered:
  - state=IDLE, lfsr=SEED, LED=0, led_valid=0, round_done=0.
  - hit_count=0, miss_count=0, prev_idx=0, spin_cnt=0, timer=0.
- LFSR step: lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
  - Steps every cycle in every state except SEED.
- States:
  - IDLE: LED=0. If enable=1, go to SEED.
  - SEED (one cycle): lfsr <= step(lfsr) ^ {8'h00, token}. If the result is 16'h0000, load SEED instead. spin_cnt <= 0. Go to SPIN.
  - SPIN: spin_cnt increments each cycle. On the edge where spin_cnt == SPIN_CYCLES-1:
    - idx = lfsr[2:0] (pre-step value).
    - LED <= 1 << idx; prev_idx <= idx; timer <= 0; go to WAIT.
  - WAIT: led_valid=1; timer increments each cycle.
    - If hit=1: hit_count += 1 (holds at 255), round_done=1, LED <= 0, go to SEED.
    - Else if timer == TIMEOUT_CYCLES-1: miss_count += 1 (holds at 255), round_done=1, LED <= 0, go to SEED.
- hit is honoured only in WAIT and ignored in every other state. This covers hit=1 while LED=0 after reset.
- If hit and timeout occur in the same cycle, the hit wins; miss_count is unchanged.
- enable=0 in any state: IDLE on the next edge, LED=0, led_valid=0. Counters and lfsr are kept. An in-flight round is dropped and not counted.
- clear=1: both counters go to 0 on that edge. If clear coincides with a round end, clear wins and the counters read 0.
- Latency: when enable is first sampled high in IDLE, LED is nonzero after edge SPIN_CYCLES+2. After a round ends, the next target appears after SPIN_CYCLES+1 edges.
- LED is always 8'h00 or exactly one bit set.
- timer width is $clog2(TIMEOUT_CYCLES).
- rst asserted mid-round: immediate return to the reset values listed above.

Optional Feature:
- Macro: RAND_NO_REPEAT_EN.
- Defined: if idx == prev_idx and at least one target has been shown since reset, use idx+1 mod 8 instead. No extra cycle is added. This stops a still-latched changed_bit in hit_or_miss from matching a repeated target and scoring an instant hit.
- Undefined: idx = lfsr[2:0] unmodified; repeats are allowed.

Test Plan:
- Reset → LED=8'h00, led_valid=0, hit_count=0, miss_count=0. hit=1 held during IDLE → counters stay 0.
- SPIN_CYCLES=4, token=8'h00, enable rises → LED one-hot with led_valid=1 after edge 6. idx matches lfsr[2:0] from the reference model.
- In WAIT, drive hit=1 for one cycle → hit_count=1, round_done pulses once, LED=0 on the next edge, new one-hot LED 5 edges later.
- TIMEOUT_CYCLES=16, no hit → after 16 WAIT cycles miss_count=1 and round_done=1. Hit on cycle 16 together with timeout → hit_count+1, miss_count unchanged.
- 300 hits → hit_count=255. Pulse clear → both counters 0 on the next edge. enable=0 mid-WAIT → LED=0 next edge, counts unchanged.
- With RAND_NO_REPEAT_EN defined, 1000 rounds → no two consecutive LED values are equal. Undefined → sequence matches the raw lfsr[2:0] reference model.
